// File: rtl/lr_pkg.sv
// Shared definitions for the serial data-point loader: default geometry,
// field-index width helper and the loader FSM state encoding.
package lr_pkg;

    localparam int DEF_WORD_W       = 16;
    localparam int DEF_NUM_FEATURES = 6;
    localparam int DEF_NUM_DP       = 6;
    localparam int DEF_ADDR_WIDTH   = 3;

    // Field index must hold 0..num_features (label sits at num_features).
    function automatic int field_w(input int num_features);
        return (num_features < 1) ? 1 : $clog2(num_features + 1);
    endfunction

    localparam int DEF_FIELD_W = field_w(DEF_NUM_FEATURES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lr_serial_loader_if.sv
// Serial-in / field-write bus of the loader. The master drives the serial
// stream and observes the write port; the slave is the loader itself.
interface lr_serial_loader_if #(
    parameter int WORD_W     = lr_pkg::DEF_WORD_W,
    parameter int ADDR_WIDTH = lr_pkg::DEF_ADDR_WIDTH,
    parameter int FIELD_W    = lr_pkg::DEF_FIELD_W
);
    logic                  ser;
    logic                  ser_en;
    logic                  dp_wr_en;
    logic [ADDR_WIDTH-1:0] dp_wr_addr;
    logic [FIELD_W-1:0]    dp_wr_field;
    logic [WORD_W-1:0]     dp_wr_data;
    logic                  busy;
    logic                  done;
    logic [WORD_W-1:0]     chk_sum;

    modport master (
        output ser, ser_en,
        input  dp_wr_en, dp_wr_addr, dp_wr_field, dp_wr_data, busy, done, chk_sum
    );

    modport slave (
        input  ser, ser_en,
        output dp_wr_en, dp_wr_addr, dp_wr_field, dp_wr_data, busy, done, chk_sum
    );

endinterface

// File: rtl/lr_shift16.sv
// Field deserializer: shift register plus bit counter. The final bit of a
// word is never stored; it is combined with the stored bits into word_o on
// the same edge the parent captures the word, so WORD_W-1 flops suffice.
module lr_shift16 #(
    parameter int WORD_W = lr_pkg::DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              ser_in,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done
);
    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-2:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign word_o    = {sr_q, ser_in};
    assign word_done = shift_en && (cnt_q == CNT_W'(WORD_W - 1));

    // Shift in one bit and advance the bit counter on each enabled cycle.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (shift_en) begin
            sr_d  = {sr_q[WORD_W-3:0], ser_in};
            cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lr_serial_loader.sv
// Serial data-point loader: deserializes NUM_DP points of NUM_FEATURES+1
// fields (label first) and emits one registered write strobe per field.
// Optional running checksum enabled by defining LR_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ST_IDLE  | waiting for the first valid serial bit
// ST_SHIFT | load in progress, fields being written
// ST_DONE  | all points written, inputs ignored until reset
module lr_serial_loader #(
    parameter int NUM_FEATURES = lr_pkg::DEF_NUM_FEATURES,
    parameter int NUM_DP       = lr_pkg::DEF_NUM_DP,
    parameter int ADDR_WIDTH   = lr_pkg::DEF_ADDR_WIDTH,
    parameter int WORD_W       = lr_pkg::DEF_WORD_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    lr_serial_loader_if.slave  bus
);
    import lr_pkg::*;

    localparam int FIELD_W = field_w(NUM_FEATURES);

    state_t                state_q, state_d;
    logic [FIELD_W-1:0]    field_q, field_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [FIELD_W-1:0]    wr_field_q, wr_field_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic                  done_q, done_d;

    logic                  shift_en;
    logic                  word_done;
    logic [WORD_W-1:0]     word;
    logic                  field_wr;

    // Serial bits are accepted in IDLE and SHIFT; DONE freezes the deserializer.
    assign shift_en = bus.ser_en && (state_q != ST_DONE);
    assign field_wr = (state_q == ST_SHIFT) && word_done;

    lr_shift16 #(.WORD_W(WORD_W)) u_shift (
        .clk       (CLK),
        .rst_n     (RST_N),
        .shift_en  (shift_en),
        .ser_in    (bus.ser),
        .word_o    (word),
        .word_done (word_done)
    );

    // Next-state, field/address counters and registered write-port values.
    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_field_d = wr_field_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ser_en) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (field_wr) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_q;
                    wr_field_d = field_q;
                    wr_data_d  = word;
                    if (field_q == '0) begin
                        field_d = FIELD_W'(NUM_FEATURES);
                        if (addr_q == ADDR_WIDTH'(NUM_DP - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                    end else begin
                        field_d = field_q - FIELD_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            field_q    <= FIELD_W'(NUM_FEATURES);
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_field_q <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_field_q <= wr_field_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

`ifdef LR_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] chk_q, chk_d;

    // Accumulate each written field so the sum lines up with its strobe.
    always_comb begin
        chk_d = chk_q;
        if (field_wr) chk_d = chk_q + word;
    end

    // Checksum register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) chk_q <= '0;
        else        chk_q <= chk_d;
    end

    assign bus.chk_sum = chk_q;
`else
    assign bus.chk_sum = '0;
`endif

    assign bus.dp_wr_en    = wr_en_q;
    assign bus.dp_wr_addr  = wr_addr_q;
    assign bus.dp_wr_field = wr_field_q;
    assign bus.dp_wr_data  = wr_data_q;
    assign bus.busy        = (state_q == ST_SHIFT);
    assign bus.done        = done_q;

endmodule
